trace_buffer: RTL and testbench

TRACE_BUFFER -- requirements
Module: trace_buffer

---
 rtl/trace_buffer.sv | 140 ++++++++++++++
 tb/tb_trace_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// trace_buffer
//   Captures one 53-bit processor snapshot {pc_out, ir_out, alu_out, rq0} each
//   time the processor FSM enters its fetch state, and presents the captured
//   entries to a consumer in FIFO order through a valid/ready read port.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   trace_en             capture enable
//   state_o              processor FSM current state
//   pc_out, ir_out,
//   alu_out, rq0         processor observation points sampled on capture
//   rd_ready             consumer accepts the head entry
//   rd_valid             head entry available (count != 0)
//   rd_data              head entry, presented combinationally from storage
//   count                number of entries held
//   overflow             sticky: a capture arrived while the buffer was full
//   drop_count           captures lost to a full buffer, saturating at 255
//
// Parameters
//   DEPTH                entry count, power of two in 2..64
//   FETCH_STATE          state_o code that marks instruction fetch
//
// Configuration
//   TRACE_OVERWRITE_EN   when defined, a capture into a full buffer overwrites
//                        the oldest entry; otherwise the capture is dropped.

module trace_buffer #(
    parameter int         DEPTH       = 8,
    parameter logic [3:0] FETCH_STATE = 4'd1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     trace_en,
    input  logic [3:0]               state_o,
    input  logic [4:0]               pc_out,
    input  logic [15:0]              ir_out,
    input  logic [15:0]              alu_out,
    input  logic [15:0]              rq0,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [52:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [52:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          prev_fetch_q, prev_fetch_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_q, drop_d;

    logic          is_fetch;
    logic          capture;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic [52:0]   sample;

    always_comb begin
        is_fetch     = (state_o == FETCH_STATE);
        // Only the first cycle of a fetch period captures, however long fetch lasts.
        capture      = trace_en && is_fetch && !prev_fetch_q;
        pop          = (count_q != '0) && rd_ready;
        full         = (count_q == FULL_COUNT);
        sample       = {pc_out, ir_out, alu_out, rq0};

        prev_fetch_d = is_fetch;
        wr_en        = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_d       = drop_q;

        if (capture && full && !pop) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
`ifdef TRACE_OVERWRITE_EN
            // When full the tail slot is the head slot: overwrite the oldest
            // entry and move both pointers so count stays at DEPTH.
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            rd_ptr_d = rd_ptr_q + PW'(1);
`else
            // Capture is dropped; storage and pointers are left untouched.
`endif
        end else begin
            // A simultaneous pop frees the slot, so capture on full is legal here.
            if (capture) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(capture) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prev_fetch_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            prev_fetch_q <= prev_fetch_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
        end
    end

    // Storage carries no reset; a capture in a reset cycle is discarded.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem_q[wr_ptr_q] <= sample;
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer
//   Self-checking bench for trace_buffer (DEPTH=8, FETCH_STATE=1). Directed
//   scenarios plus randomized traffic, compared against a queue-based model.
//   Honours TRACE_OVERWRITE_EN to select the expected full-buffer policy.

module tb_trace_buffer;

    localparam int         DEPTH = 8;
    localparam logic [3:0] FS    = 4'd1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b0;
    logic [3:0]  state_o = 4'd0;
    logic [4:0]  pc_out = '0;
    logic [15:0] ir_out = '0;
    logic [15:0] alu_out = '0;
    logic [15:0] rq0 = '0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [52:0] rd_data;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [52:0] m_q[$];
    bit          m_prev;
    bit          m_ovf;
    int          m_drop;

    trace_buffer #(.DEPTH(DEPTH), .FETCH_STATE(FS)) dut (
        .clock(clock), .reset(reset), .trace_en(trace_en), .state_o(state_o),
        .pc_out(pc_out), .ir_out(ir_out), .alu_out(alu_out), .rq0(rq0),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    function automatic logic [52:0] samp(input int i);
        logic [4:0] p;
        p = 5'(i);
        return {p, 16'(16'hA000 + i), 16'(16'h5000 + i * 3), 16'(i * 7)};
    endfunction

    // One clock cycle: drive inputs, advance the model on the edge, sample at +1.
    task automatic tick(input logic en, input logic [3:0] st, input logic [52:0] d, input logic rdy);
        bit cap;
        bit pop;
        trace_en = en;
        state_o  = st;
        {pc_out, ir_out, alu_out, rq0} = d;
        rd_ready = rdy;
        @(posedge clock);
        cap    = en && (st == FS) && !m_prev;
        m_prev = (st == FS);
        pop    = (m_q.size() != 0) && rdy;
        if (cap && m_q.size() == DEPTH && !pop) begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
`ifdef TRACE_OVERWRITE_EN
            void'(m_q.pop_front());
            m_q.push_back(d);
`endif
        end else begin
            if (pop) void'(m_q.pop_front());
            if (cap) m_q.push_back(d);
        end
        #1;
    endtask

    task automatic do_reset(input logic en, input logic [3:0] st, input logic [52:0] d, input logic rdy);
        reset    = 1'b1;
        trace_en = en;
        state_o  = st;
        {pc_out, ir_out, alu_out, rq0} = d;
        rd_ready = rdy;
        @(posedge clock);
        m_q.delete();
        m_prev = 0;
        m_ovf  = 0;
        m_drop = 0;
        #1;
        reset = 1'b0;
    endtask

    // Enter fetch from a non-fetch cycle: exactly one capture of samp(i).
    task automatic cap_one(input int i, input logic rdy);
        tick(1'b1, 4'd0, '0, 1'b0);
        tick(1'b1, FS, samp(i), rdy);
    endtask

    task automatic test_reset();
        do_reset(1'b1, FS, samp(77), 1'b1);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
    endtask

    task automatic test_fetch_edge();
        logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd1};
        do_reset(1'b0, 4'd0, '0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, seq[i], samp(20 + i), 1'b0);
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL fetch_edge_count got=%0d exp=2", count); end
        checks++; if (rd_data !== samp(21)) begin failures++; $display("FAIL fetch_edge_head got=%h exp=%h", rd_data, samp(21)); end
        tick(1'b0, 4'd0, '0, 1'b1);
        checks++; if (rd_data !== samp(25)) begin failures++; $display("FAIL fetch_edge_second got=%h exp=%h", rd_data, samp(25)); end
    endtask

    task automatic test_latency();
        logic [52:0] exp_d;
        exp_d = {5'd3, 16'h1234, 16'h00FF, 16'h0007};
        do_reset(1'b0, 4'd0, '0, 1'b0);
        tick(1'b1, 4'd0, '0, 1'b1);
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL latency_pre_valid got=%b exp=0", rd_valid); end
        // rd_ready held high on an empty buffer: the pop is ignored, capture kept.
        tick(1'b1, FS, exp_d, 1'b1);
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== exp_d) begin failures++; $display("FAIL latency_data got=%h exp=%h", rd_data, exp_d); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL latency_count got=%0d exp=1", count); end
    endtask

    task automatic test_overflow();
        int first;
`ifdef TRACE_OVERWRITE_EN
        first = 3;
`else
        first = 1;
`endif
        do_reset(1'b0, 4'd0, '0, 1'b0);
        for (int i = 1; i <= 10; i++) cap_one(i, 1'b0);
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL ovf_drop got=%0d exp=2", drop_count); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (rd_valid !== 1'b1 || rd_data !== samp(first + k)) begin
                failures++; $display("FAIL ovf_pop%0d got=%b/%h exp=1/%h", k, rd_valid, rd_data, samp(first + k));
            end
            tick(1'b0, 4'd0, '0, 1'b1);
        end
        checks++; if (rd_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL ovf_drained got=%b/%0d exp=0/0", rd_valid, count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_cap_pop();
        do_reset(1'b0, 4'd0, '0, 1'b0);
        for (int i = 1; i <= 8; i++) cap_one(i, 1'b0);
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL fullcp_pre_count got=%0d exp=8", count); end
        cap_one(9, 1'b1);
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL fullcp_count got=%0d exp=8", count); end
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL fullcp_ovf got=%b/%0d exp=0/0", overflow, drop_count); end
        for (int k = 2; k <= 9; k++) begin
            checks++; if (rd_data !== samp(k)) begin failures++; $display("FAIL fullcp_pop%0d got=%h exp=%h", k, rd_data, samp(k)); end
            tick(1'b0, 4'd0, '0, 1'b1);
        end
    endtask

    task automatic test_saturate();
        int head;
`ifdef TRACE_OVERWRITE_EN
        head = 261;
`else
        head = 1;
`endif
        do_reset(1'b0, 4'd0, '0, 1'b0);
        for (int i = 1; i <= 268; i++) cap_one(i, 1'b0);
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL sat_drop got=%0d exp=255", drop_count); end
        checks++; if (count !== 4'd8 || overflow !== 1'b1) begin failures++; $display("FAIL sat_state got=%0d/%b exp=8/1", count, overflow); end
        checks++; if (rd_data !== samp(head)) begin failures++; $display("FAIL sat_head got=%h exp=%h", rd_data, samp(head)); end
    endtask

    // Runs after test_saturate: buffer full, overflow set, drop_count at 255.
    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) tick(1'b0, 4'd0, '0, 1'b1);
        checks++; if (count !== 4'd5) begin failures++; $display("FAIL rmid_pre_count got=%0d exp=5", count); end
        do_reset(1'b1, FS, samp(99), 1'b1);
        checks++; if (count !== 4'd0 || rd_valid !== 1'b0) begin failures++; $display("FAIL rmid_count got=%0d/%b exp=0/0", count, rd_valid); end
        checks++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL rmid_flags got=%b/%0d exp=0/0", overflow, drop_count); end
        // state_o was fetch during reset, yet the first post-reset fetch cycle captures.
        tick(1'b1, FS, samp(42), 1'b0);
        checks++; if (count !== 4'd1 || rd_data !== samp(42)) begin failures++; $display("FAIL rmid_first got=%0d/%h exp=1/%h", count, rd_data, samp(42)); end
    endtask

    task automatic test_random();
        logic [3:0]  st;
        logic [52:0] d;
        logic        en;
        logic        rdy;
        do_reset(1'b0, 4'd0, '0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            en  = ($urandom_range(0, 9) != 0);
            st  = ($urandom_range(0, 1) == 0) ? FS : 4'($urandom_range(0, 15));
            d   = {$urandom, $urandom};
            rdy = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) do_reset(en, st, d, rdy);
            else tick(en, st, d, rdy);
            checks++; if (count !== 4'(m_q.size())) begin failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, count, m_q.size()); end
            checks++; if (rd_valid !== (m_q.size() != 0)) begin failures++; $display("FAIL rand_valid c=%0d got=%b", c, rd_valid); end
            checks++; if (overflow !== m_ovf || drop_count !== 8'(m_drop)) begin
                failures++; $display("FAIL rand_flags c=%0d got=%b/%0d exp=%b/%0d", c, overflow, drop_count, m_ovf, m_drop);
            end
            if (m_q.size() != 0) begin
                checks++; if (rd_data !== m_q[0]) begin failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, rd_data, m_q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_edge();
        test_latency();
        test_overflow();
        test_full_cap_pop();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
